noc_out_port: RTL and testbench
===============================

// Module: noc_out_port
// PURPOSE
//  Output-port datapath that consumes one rotating one-hot turn vector from the router arbiter.
//  - Selects the granted input channel (N,S,E,W,L) and accepts its flit.
//  - Buffers accepted flits in a small FIFO and drives them onto the downstream link with valid/ready.
//  - One instance sits behind each of the five N/S/E/W/L turn outputs of the router arbiter.
// PARAMETERS
//  FLIT_W      32       flit width in bits
//  FIFO_DEPTH  4        output FIFO entries; power of 2, >=2
//  SELF_MASK   5'b00000 inputs never granted (own direction), bit order {N,S,E,W,L}
//  CNT_W       16       statistics counter width (used only with NOC_OUT_STATS_EN)
// PORTS
//  clk          in   1                  clock, all state on posedge
//  rst          in   1                  asynchronous reset, active-low
//  turn_i       in   5                  one-hot grant from arbiter, {N,S,E,W,L}
//  in_valid_i   in   5                  per-input flit valid, {N,S,E,W,L}
//  in_data_i    in   5*FLIT_W           packed flits; N at [5*FLIT_W-1 -: FLIT_W], L at [FLIT_W-1:0]
//  in_ready_o   in/out: out 5           per-input accept strobe
//  out_valid_o  out  1                  downstream flit valid
//  out_data_o   out  FLIT_W             downstream flit
//  out_ready_i  in   1                  downstream ready
//  fifo_cnt_o   out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
//  turn_err_o   out  1                  sticky: turn_i had >1 bit set
//  stat_cnt_o   out  5*CNT_W            per-input forwarded-flit counts (NOC_OUT_STATS_EN only)
// BEHAVIOUR
//  - Reset (rst=0, async): all outputs 0. Pointers, count, turn_err_o and stat counters cleared.
//    FIFO contents discarded. Reset mid-transfer drops buffered flits with no partial output.
//  - Grant: gnt = turn_i & ~SELF_MASK, valid only if gnt is exactly one-hot; otherwise gnt = 0.
//    Zero or multi-hot turn grants nothing that cycle.
//  - in_ready_o[k] = gnt[k] & ~full, combinational. Only the granted input ever sees ready.
//  - Push when in_valid_i[k] & in_ready_o[k]: FLIT_W slice k is written at the write pointer.
//  - Pop when out_valid_o & out_ready_i. out_valid_o = (count != 0).
//    out_data_o = mem[rd_ptr], driven from registered storage.
//  - Latency: a flit pushed in cycle t is visible on out_data_o with out_valid_o=1 in cycle t+1 (empty FIFO).
//  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
//    count = FIFO_DEPTH means full; count = 0 means empty.
//  - Simultaneous push+pop: count unchanged, both pointers advance.
//    When full, ready is 0 even if a pop occurs the same cycle (no bypass).
//  - Empty with out_ready_i=1: no pop, out_valid_o stays 0, no pointer change.
//  - out_valid_o/out_data_o are held stable while out_valid_o=1 & out_ready_i=0.
//  - turn_err_o sets on any cycle with $countones(turn_i)>1 and clears only on reset.
//  - in_valid_i with no grant is ignored: no state change, and the source must hold its flit.
// CONFIGURATION
//  NOC_OUT_STATS_EN defined:
//    - stat_cnt_o[k] increments on each push from input k.
//    - Counters saturate at 2^CNT_W-1 and never wrap.
//  NOC_OUT_STATS_EN undefined: stat_cnt_o tied to 0 and no counter flops are instantiated.
// TESTING
//  1. turn_i=5'b10000, N valid data=32'hA5A5_0001, out_ready_i=1:
//     in_ready_o=5'b10000, and out_data_o=32'hA5A5_0001 with out_valid_o=1 one cycle later.
//  2. SELF_MASK=5'b01000, turn_i=5'b01000, S valid: in_ready_o=0, no push, fifo_cnt_o stays 0.
//  3. out_ready_i=0, turn cycling with all inputs valid, 4 pushes:
//     fifo_cnt_o=4 and in_ready_o=0. Then out_ready_i=1 drains 4 flits in push order, 1 per cycle.
//  4. count=2 with push and pop in the same cycle: fifo_cnt_o stays 2.
//     Run 10 push/pop pairs to confirm pointer wrap and data order.
//  5. turn_i=5'b00110 for 1 cycle: no ready and turn_err_o=1, held through later valid turns.
//     Assert rst=0 asynchronously: turn_err_o, fifo_cnt_o and out_valid_o go to 0 immediately.
//  6. NOC_OUT_STATS_EN, CNT_W=4, 20 pushes from L: stat_cnt_o L slice reads 4'hF.
//     Without the macro, stat_cnt_o stays 0.

Source files
------------

// File: rtl/noc_out_port.sv
// noc_out_port: arbiter-driven output port, one-hot grant select into a small FIFO feeding a valid/ready link.
// Optional per-input forwarded-flit counters are built when NOC_OUT_STATS_EN is defined.
module noc_out_port #(
  parameter int FLIT_W = 32,
  parameter int FIFO_DEPTH = 4,
  parameter logic [4:0] SELF_MASK = 5'b00000,
  parameter int CNT_W = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [4:0]                      turn_i,
  input  logic [4:0]                      in_valid_i,
  input  logic [5*FLIT_W-1:0]             in_data_i,
  output logic [4:0]                      in_ready_o,
  output logic                            out_valid_o,
  output logic [FLIT_W-1:0]               out_data_o,
  input  logic                            out_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_cnt_o,
  output logic                            turn_err_o,
  output logic [5*CNT_W-1:0]              stat_cnt_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [4:0] masked, gnt;
  logic full, push, pop, multi;
  logic [FLIT_W-1:0] push_data;
  logic [FLIT_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  always_comb begin
    masked = turn_i & ~SELF_MASK;
    gnt = (masked != 5'd0 && (masked & (masked - 5'd1)) == 5'd0) ? masked : 5'd0;
    multi = (turn_i & (turn_i - 5'd1)) != 5'd0;
    full = cnt_q == CW'(FIFO_DEPTH);
    in_ready_o = full ? 5'd0 : gnt;
    push = |(in_valid_i & in_ready_o);
    pop = out_valid_o & out_ready_i;
    push_data = '0;
    for (int k = 0; k < 5; k++)
      push_data = push_data | (in_data_i[k*FLIT_W +: FLIT_W] & {FLIT_W{gnt[k]}});
    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    err_d = err_q | multi;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      if (push) mem_q[wr_q] <= push_data;
    end
  end
  assign out_valid_o = cnt_q != '0;
  assign out_data_o = mem_q[rd_q];
  assign fifo_cnt_o = cnt_q;
  assign turn_err_o = err_q;
`ifdef NOC_OUT_STATS_EN
  // Saturating counters: stop at all-ones rather than wrapping.
  for (genvar k = 0; k < 5; k++) begin : g_stat
    logic [CNT_W-1:0] stat_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) stat_q <= '0;
      else if (push && gnt[k] && stat_q != '1) stat_q <= stat_q + 1'b1;
    end
    assign stat_cnt_o[k*CNT_W +: CNT_W] = stat_q;
  end
`else
  assign stat_cnt_o = '0;
`endif
endmodule

// File: tb/tb_noc_out_port.sv
// tb_noc_out_port: directed checks of grant select, FIFO order/wrap, full/empty, turn error, reset and stats.
module tb_noc_out_port;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] turn_i, in_valid_i, in_ready_o;
  logic [159:0] in_data_i;
  logic out_valid_o, out_ready_i, turn_err_o;
  logic [31:0] out_data_o;
  logic [2:0] fifo_cnt_o;
  logic [19:0] stat_cnt_o;
  int compared = 0;
  int mismatched = 0;
  logic [31:0] exp_q [4];
  logic [31:0] base;

  always #5 clk = ~clk;

  noc_out_port #(.FLIT_W(32), .FIFO_DEPTH(4), .SELF_MASK(5'b01000), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .turn_i(turn_i), .in_valid_i(in_valid_i), .in_data_i(in_data_i),
    .in_ready_o(in_ready_o), .out_valid_o(out_valid_o), .out_data_o(out_data_o),
    .out_ready_i(out_ready_i), .fifo_cnt_o(fifo_cnt_o), .turn_err_o(turn_err_o),
    .stat_cnt_o(stat_cnt_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; turn_i = '0; in_valid_i = '0; in_data_i = '0; out_ready_i = 1'b0;
    #3;
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_cnt", 64'(fifo_cnt_o), 64'd0);
    chk("rst_data", 64'(out_data_o), 64'd0);
    chk("rst_err", 64'(turn_err_o), 64'd0);
    chk("rst_ready", 64'(in_ready_o), 64'd0);
    chk("rst_stat", 64'(stat_cnt_o), 64'd0);
    #9 rst = 1'b1;
    tick();
    // 1: single flit from N, one-cycle latency
    turn_i = 5'b10000; in_valid_i = 5'b10000; in_data_i[4*32 +: 32] = 32'hA5A5_0001; out_ready_i = 1'b1;
    #1;
    chk("t1_ready", 64'(in_ready_o), 64'h10);
    chk("t1_valid_pre", 64'(out_valid_o), 64'd0);
    tick();
    turn_i = '0; in_valid_i = '0;
    #1;
    chk("t1_valid", 64'(out_valid_o), 64'd1);
    chk("t1_data", 64'(out_data_o), 64'hA5A5_0001);
    chk("t1_cnt", 64'(fifo_cnt_o), 64'd1);
    tick();
    chk("t1_empty", 64'(out_valid_o), 64'd0);
    chk("t1_cnt0", 64'(fifo_cnt_o), 64'd0);
    // 2: masked self direction
    turn_i = 5'b01000; in_valid_i = 5'b01000;
    #1;
    chk("t2_ready", 64'(in_ready_o), 64'd0);
    tick();
    chk("t2_cnt", 64'(fifo_cnt_o), 64'd0);
    chk("t2_valid", 64'(out_valid_o), 64'd0);
    // 3: fill with turn cycling, then drain in order
    out_ready_i = 1'b0; in_valid_i = 5'b11111;
    in_data_i = {32'hC0DE_0004, 32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
    exp_q = '{32'hC0DE_0004, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
    turn_i = 5'b10000; tick();
    turn_i = 5'b00100; tick();
    turn_i = 5'b00010; tick();
    turn_i = 5'b00001; tick();
    chk("t3_full_cnt", 64'(fifo_cnt_o), 64'd4);
    turn_i = 5'b10000;
    #1;
    chk("t3_full_ready", 64'(in_ready_o), 64'd0);
    chk("t3_hold_data", 64'(out_data_o), 64'(exp_q[0]));
    tick();
    chk("t3_hold_cnt", 64'(fifo_cnt_o), 64'd4);
    chk("t3_hold_data2", 64'(out_data_o), 64'(exp_q[0]));
    out_ready_i = 1'b1;
    #1;
    chk("t3_nobypass", 64'(in_ready_o), 64'd0);
    tick();
    turn_i = '0; in_valid_i = '0;
    chk("t3_cnt3", 64'(fifo_cnt_o), 64'd3);
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("t3_drain%0d_valid", i), 64'(out_valid_o), 64'd1);
      chk($sformatf("t3_drain%0d_data", i), 64'(out_data_o), 64'(exp_q[i]));
      tick();
    end
    chk("t3_empty", 64'(out_valid_o), 64'd0);
    // 4: steady push+pop at count 2, pointers wrap
    base = 32'h5000_0000;
    out_ready_i = 1'b0; turn_i = 5'b00001; in_valid_i = 5'b00001;
    in_data_i[31:0] = base; tick();
    in_data_i[31:0] = base + 1; tick();
    chk("t4_cnt2", 64'(fifo_cnt_o), 64'd2);
    out_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data_i[31:0] = base + 32'(i) + 2;
      #1;
      chk($sformatf("t4_data%0d", i), 64'(out_data_o), 64'(base + 32'(i)));
      tick();
      chk($sformatf("t4_cnt%0d", i), 64'(fifo_cnt_o), 64'd2);
    end
    in_valid_i = '0; turn_i = '0;
    #1;
    chk("t4_tail0", 64'(out_data_o), 64'(base + 10));
    tick();
    chk("t4_tail1", 64'(out_data_o), 64'(base + 11));
    tick();
    chk("t4_empty", 64'(fifo_cnt_o), 64'd0);
    // empty with ready high: nothing moves
    tick();
    chk("t4_empty_hold", 64'(out_valid_o), 64'd0);
    // 5: multi-hot turn, sticky error, async reset
    out_ready_i = 1'b0; turn_i = 5'b00110; in_valid_i = 5'b11111;
    #1;
    chk("t5_ready", 64'(in_ready_o), 64'd0);
    tick();
    chk("t5_err", 64'(turn_err_o), 64'd1);
    chk("t5_cnt0", 64'(fifo_cnt_o), 64'd0);
    turn_i = 5'b00001; in_data_i[31:0] = 32'hDEAD_BEEF;
    tick();
    turn_i = '0; in_valid_i = '0;
    chk("t5_err_held", 64'(turn_err_o), 64'd1);
    chk("t5_cnt1", 64'(fifo_cnt_o), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_err", 64'(turn_err_o), 64'd0);
    chk("t5_rst_cnt", 64'(fifo_cnt_o), 64'd0);
    chk("t5_rst_valid", 64'(out_valid_o), 64'd0);
    chk("t5_rst_data", 64'(out_data_o), 64'd0);
    #3 rst = 1'b1;
    tick();
    // 6: stats from L, saturating at 4'hF when enabled
    out_ready_i = 1'b1; turn_i = 5'b00001; in_valid_i = 5'b00001;
    for (int i = 0; i < 5; i++) tick();
`ifdef NOC_OUT_STATS_EN
    chk("t6_stat5", 64'(stat_cnt_o), 64'h5);
`else
    chk("t6_stat5", 64'(stat_cnt_o), 64'h0);
`endif
    for (int i = 0; i < 15; i++) tick();
    turn_i = '0; in_valid_i = '0;
    tick();
`ifdef NOC_OUT_STATS_EN
    chk("t6_stat_sat", 64'(stat_cnt_o), 64'hF);
`else
    chk("t6_stat_sat", 64'(stat_cnt_o), 64'h0);
`endif
    chk("t6_cnt", 64'(fifo_cnt_o), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
